// File: rtl/matrix_loader.sv
// ---------------------------------------------------------------------------
// matrix_loader
//   Serial loader for two small operand matrices. A nibble stream is read as
//   a four-entry dimension header (ctrl_logic=1: R1, C1, R2, C2) followed by
//   a data phase (ctrl_logic=0) that fills matrix_1 then matrix_2 row-major.
//
// Ports
//   CLK         in   clock, all state changes on the rising edge
//   RST         in   synchronous active-high reset
//   data_send   in   DATA_W   dimension (header phase) or element (data phase)
//   ctrl_logic  in   1 = header phase, 0 = data phase
//   R1,C1,R2,C2 out  DATA_W   stored dimensions
//   matrix_1    out  MAX_DIM*MAX_DIM*DATA_W, element k at [k*DATA_W +: DATA_W]
//   matrix_2    out  same layout as matrix_1
//   loaded      out  both matrices completely loaded
//   size_err    out  header incomplete or a dimension is 0 / > MAX_DIM
// ---------------------------------------------------------------------------
module matrix_loader #(
    parameter int DATA_W  = 4,
    parameter int MAX_DIM = 2
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic [DATA_W-1:0]                   data_send,
    input  logic                                ctrl_logic,
    output logic [DATA_W-1:0]                   R1,
    output logic [DATA_W-1:0]                   C1,
    output logic [DATA_W-1:0]                   R2,
    output logic [DATA_W-1:0]                   C2,
    output logic [MAX_DIM*MAX_DIM*DATA_W-1:0]   matrix_1,
    output logic [MAX_DIM*MAX_DIM*DATA_W-1:0]   matrix_2,
    output logic                                loaded,
    output logic                                size_err
);

    localparam int NELEM = MAX_DIM * MAX_DIM;
    localparam int CNT_W = 2 * DATA_W;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR   = 3'd1;
    localparam logic [2:0] S_LOAD1 = 3'd2;
    localparam logic [2:0] S_LOAD2 = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    logic [2:0]        r_state;
    logic [2:0]        r_hdr_idx;   // number of header nibbles taken, saturates at 4
    logic [CNT_W-1:0]  r_k;         // element index within the matrix being loaded
    logic [DATA_W-1:0] r_r1;
    logic [DATA_W-1:0] r_c1;
    logic [DATA_W-1:0] r_r2;
    logic [DATA_W-1:0] r_c2;
    logic              r_loaded;
    logic              r_size_err;

    logic [CNT_W-1:0]  w_prod1;
    logic [CNT_W-1:0]  w_prod2;
    logic              w_hdr_ok;
    logic              w_start;
    logic              w_wr1;
    logic              w_wr2;
    logic [CNT_W-1:0]  w_wr_k;
    logic [CNT_W-1:0]  w_k_next;

    function automatic logic dim_ok(input logic [DATA_W-1:0] d);
        return (d != '0) && (d <= DATA_W'(MAX_DIM));
    endfunction

    // Products at double width so no dimension combination can wrap.
    assign w_prod1  = CNT_W'(r_r1) * CNT_W'(r_c1);
    assign w_prod2  = CNT_W'(r_r2) * CNT_W'(r_c2);

    assign w_hdr_ok = (r_hdr_idx == 3'd4) && dim_ok(r_r1) && dim_ok(r_c1)
                      && dim_ok(r_r2) && dim_ok(r_c2);

    // The edge that leaves a valid header already carries element 0 of matrix_1.
    assign w_start  = (r_state == S_HDR) && !ctrl_logic && w_hdr_ok;
    assign w_wr1    = !ctrl_logic && (w_start || (r_state == S_LOAD1));
    assign w_wr2    = !ctrl_logic && (r_state == S_LOAD2);
    assign w_wr_k   = w_start ? '0 : r_k;
    assign w_k_next = w_wr_k + 1'b1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_hdr_idx  <= '0;
            r_k        <= '0;
            r_r1       <= '0;
            r_c1       <= '0;
            r_r2       <= '0;
            r_c2       <= '0;
            r_loaded   <= 1'b0;
            r_size_err <= 1'b0;
        end else if (ctrl_logic) begin
            if (r_state != S_HDR) begin
                // A header from any other state restarts the whole load.
                r_state    <= S_HDR;
                r_r1       <= data_send;
                r_hdr_idx  <= 3'd1;
                r_k        <= '0;
                r_loaded   <= 1'b0;
                r_size_err <= 1'b0;
            end else if (r_hdr_idx < 3'd4) begin
                case (r_hdr_idx)
                    3'd0:    r_r1 <= data_send;
                    3'd1:    r_c1 <= data_send;
                    3'd2:    r_r2 <= data_send;
                    default: r_c2 <= data_send;
                endcase
                r_hdr_idx <= r_hdr_idx + 3'd1;
            end
        end else begin
            case (r_state)
                S_HDR, S_LOAD1: begin
                    if (r_state == S_HDR && !w_hdr_ok) begin
                        r_state    <= S_ERR;
                        r_size_err <= 1'b1;
                    end else if (w_k_next == w_prod1) begin
                        r_state <= S_LOAD2;
                        r_k     <= '0;
                    end else begin
                        r_state <= S_LOAD1;
                        r_k     <= w_k_next;
                    end
                end
                S_LOAD2: begin
                    if (w_k_next == w_prod2) begin
                        r_state  <= S_DONE;
                        r_loaded <= 1'b1;
                        r_k      <= '0;
                    end else begin
                        r_k <= w_k_next;
                    end
                end
                default: begin
                    // IDLE, DONE, ERR: data nibbles are ignored.
                end
            endcase
        end
    end

    // One register per matrix slot; slots beyond R*C are never addressed and
    // so keep whatever an earlier load left there.
    generate
        for (genvar gi = 0; gi < NELEM; gi++) begin : g_elem
            logic [DATA_W-1:0] r_elem1;
            logic [DATA_W-1:0] r_elem2;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_elem1 <= '0;
                    r_elem2 <= '0;
                end else begin
                    if (w_wr1 && (w_wr_k == CNT_W'(gi)))
                        r_elem1 <= data_send;
                    if (w_wr2 && (r_k == CNT_W'(gi)))
                        r_elem2 <= data_send;
                end
            end

            assign matrix_1[gi*DATA_W +: DATA_W] = r_elem1;
            assign matrix_2[gi*DATA_W +: DATA_W] = r_elem2;
        end
    endgenerate

    assign R1       = r_r1;
    assign C1       = r_c1;
    assign R2       = r_r2;
    assign C2       = r_c2;
    assign loaded   = r_loaded;
    assign size_err = r_size_err;

endmodule

// File: tb/tb_matrix_loader.sv
// ---------------------------------------------------------------------------
// tb_matrix_loader
//   Self-checking bench for matrix_loader. A reference model tracks the load
//   as "number of data nibbles since a valid header": nibble n goes to
//   matrix_1[n] while n < R1*C1, else matrix_2[n-R1*C1], and the load is
//   complete once n reaches R1*C1 + R2*C2.
// ---------------------------------------------------------------------------
module tb_matrix_loader;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [3:0]  data_send = '0;
    logic        ctrl_logic = 1'b0;
    logic [3:0]  R1, C1, R2, C2;
    logic [15:0] matrix_1, matrix_2;
    logic        loaded, size_err;

    int errors = 0;
    int checks = 0;

    matrix_loader #(.DATA_W(4), .MAX_DIM(2)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .data_send  (data_send),
        .ctrl_logic (ctrl_logic),
        .R1         (R1),
        .C1         (C1),
        .R2         (R2),
        .C2         (C2),
        .matrix_1   (matrix_1),
        .matrix_2   (matrix_2),
        .loaded     (loaded),
        .size_err   (size_err)
    );

    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    int m_dims[4];
    int m_hdr_cnt;
    bit m_in_hdr;
    bit m_active;
    bit m_loaded;
    bit m_err;
    int m_dcnt;
    int m_m1[4];
    int m_m2[4];

    function automatic void model_clear();
        for (int i = 0; i < 4; i++) begin
            m_dims[i] = 0; m_m1[i] = 0; m_m2[i] = 0;
        end
        m_hdr_cnt = 0; m_in_hdr = 0; m_active = 0;
        m_loaded = 0;  m_err = 0;    m_dcnt = 0;
    endfunction

    function automatic void model_update(input bit rst, input bit ctrl, input int d);
        int p1, p2;
        bit bad;
        if (rst) begin
            model_clear();
        end else if (ctrl) begin
            if (!m_in_hdr) begin
                m_in_hdr = 1; m_hdr_cnt = 0;
                m_loaded = 0; m_err = 0; m_active = 0;
            end
            if (m_hdr_cnt < 4) begin
                m_dims[m_hdr_cnt] = d;
                m_hdr_cnt++;
            end
        end else begin
            if (m_in_hdr) begin
                m_in_hdr = 0;
                bad = (m_hdr_cnt < 4);
                for (int i = 0; i < 4; i++)
                    if (m_dims[i] == 0 || m_dims[i] > 2) bad = 1;
                if (bad) m_err = 1;
                else begin
                    m_active = 1; m_dcnt = 0;
                end
            end
            if (m_active) begin
                p1 = m_dims[0] * m_dims[1];
                p2 = m_dims[2] * m_dims[3];
                if (m_dcnt < p1) m_m1[m_dcnt] = d;
                else             m_m2[m_dcnt - p1] = d;
                m_dcnt++;
                if (m_dcnt == p1 + p2) begin
                    m_loaded = 1; m_active = 0;
                end
            end
        end
    endfunction

    function automatic logic [49:0] exp_vec();
        logic [15:0] f1, f2;
        logic [3:0]  dd[4];
        for (int k = 0; k < 4; k++) begin
            f1[k*4 +: 4] = 4'(m_m1[k]);
            f2[k*4 +: 4] = 4'(m_m2[k]);
            dd[k]        = 4'(m_dims[k]);
        end
        return {dd[0], dd[1], dd[2], dd[3], f1, f2, m_loaded, m_err};
    endfunction

    wire [49:0] dut_vec = {R1, C1, R2, C2, matrix_1, matrix_2, loaded, size_err};

    // Drive one edge, advance the model, then settle 1 time unit past the edge.
    task automatic step(input bit rst, input bit ctrl, input logic [3:0] d);
        RST = rst; ctrl_logic = ctrl; data_send = d;
        @(posedge CLK);
        model_update(rst, ctrl, int'(d));
        #1;
        $display("step rst=%0b ctrl=%0b data=%h -> dims=%h%h%h%h m1=%h m2=%h loaded=%0b size_err=%0b",
                 rst, ctrl, d, R1, C1, R2, C2, matrix_1, matrix_2, loaded, size_err);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        step(1, 0, 4'h0);
        step(1, 1, 4'h5);
        checks++;
        if (dut_vec !== 50'd0) begin
            errors++;
            $display("FAIL reset got=%h exp=0", dut_vec);
        end
    endtask

    task automatic test_no_header();
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 4'($urandom_range(0, 15)));
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL no_header[%0d] got=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
        checks++;
        if (dut_vec !== 50'd0) begin
            errors++;
            $display("FAIL no_header_zero got=%h exp=0", dut_vec);
        end
    endtask

    task automatic load_2x2(input string name, input logic [3:0] d[8], input int stop_after);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 4'h2);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL %s_hdr[%0d] got=%h exp=%h", name, i, dut_vec, exp_vec());
            end
        end
        for (int i = 0; i < stop_after; i++) begin
            step(0, 0, d[i]);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL %s_data[%0d] got=%h exp=%h", name, i, dut_vec, exp_vec());
            end
            if (i == 6) begin
                checks++;
                if (loaded !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_early_loaded got=%0b exp=0", name, loaded);
                end
            end
        end
    endtask

    task automatic test_basic();
        logic [3:0] d[8] = '{4'd1, 4'd15, 4'd2, 4'd2, 4'd1, 4'd15, 4'd2, 4'd2};
        load_2x2("basic", d, 8);
        for (int i = 0; i < 3; i++) step(0, 0, 4'($urandom_range(0, 15)));
        checks++;
        if ({R1, C1, R2, C2, matrix_1, matrix_2, loaded, size_err} !== {16'h2222, 16'h22F1, 16'h22F1, 2'b10}) begin
            errors++;
            $display("FAIL basic_final got=%h exp=%h", dut_vec, {16'h2222, 16'h22F1, 16'h22F1, 2'b10});
        end
    endtask

    task automatic test_rect();
        logic [3:0] h[4] = '{4'd1, 4'd2, 4'd2, 4'd1};
        logic [3:0] d[6] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
        for (int i = 0; i < 4; i++) begin
            step(0, 1, h[i]);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL rect_hdr[%0d] got=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
        for (int i = 0; i < 6; i++) begin
            step(0, 0, d[i]);
            checks++;
            if (dut_vec !== exp_vec() || loaded !== (i >= 3)) begin
                errors++;
                $display("FAIL rect_data[%0d] got=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
        checks++;
        if ({matrix_1, matrix_2} !== {16'h2243, 16'h2265}) begin
            errors++;
            $display("FAIL rect_final got=%h exp=%h", {matrix_1, matrix_2}, {16'h2243, 16'h2265});
        end
    endtask

    task automatic test_reload();
        logic [3:0] d[8] = '{default: 4'd9};
        step(0, 1, 4'h2);
        checks++;
        if (loaded !== 1'b0) begin
            errors++;
            $display("FAIL reload_drop got=%0b exp=0", loaded);
        end
        for (int i = 0; i < 3; i++) step(0, 1, 4'h2);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, d[i]);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL reload_data[%0d] got=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
        checks++;
        if ({matrix_1, matrix_2, loaded} !== {16'h9999, 16'h9999, 1'b1}) begin
            errors++;
            $display("FAIL reload_final got=%h exp=%h", {matrix_1, matrix_2, loaded}, {16'h9999, 16'h9999, 1'b1});
        end
    endtask

    task automatic test_size_err();
        logic [3:0] h[4] = '{4'd3, 4'd2, 4'd2, 4'd2};
        step(1, 0, 4'h0);
        for (int i = 0; i < 4; i++) step(0, 1, h[i]);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 4'($urandom_range(0, 15)));
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL size_err_data[%0d] got=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
        checks++;
        if ({size_err, loaded, matrix_1, matrix_2} !== {2'b10, 32'h0}) begin
            errors++;
            $display("FAIL size_err_final got=%h exp=%h", {size_err, loaded, matrix_1, matrix_2}, {2'b10, 32'h0});
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] d[8] = '{4'd1, 4'd15, 4'd2, 4'd2, 4'd1, 4'd15, 4'd2, 4'd2};
        logic [3:0] e[8] = '{4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14};
        step(1, 0, 4'h0);
        load_2x2("mid", d, 3);
        step(1, 0, 4'h3);
        checks++;
        if (dut_vec !== 50'd0) begin
            errors++;
            $display("FAIL reset_mid got=%h exp=0", dut_vec);
        end
        load_2x2("after_rst", e, 8);
        checks++;
        if ({matrix_1, matrix_2, loaded} !== {16'hA987, 16'hEDCB, 1'b1}) begin
            errors++;
            $display("FAIL after_rst_final got=%h exp=%h", {matrix_1, matrix_2, loaded}, {16'hA987, 16'hEDCB, 1'b1});
        end
    endtask

    task automatic test_random();
        int hl, dl;
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 9) == 0) step(1, 0, 4'h0);
            hl = $urandom_range(3, 6);
            for (int i = 0; i < hl; i++)
                step(0, 1, ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                      : 4'($urandom_range(1, 2)));
            dl = $urandom_range(0, 10);
            for (int i = 0; i < dl; i++) begin
                step(0, 0, 4'($urandom_range(0, 15)));
                checks++;
                if (dut_vec !== exp_vec()) begin
                    errors++;
                    $display("FAIL random[%0d.%0d] got=%h exp=%h", t, i, dut_vec, exp_vec());
                end
            end
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random_end[%0d] got=%h exp=%h", t, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_no_header();
        test_basic();
        test_rect();
        test_reload();
        test_size_err();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
